// File: rtl/matmul_tile_mnk.sv
// Signed integer matrix-multiply tile: C[M][N] (+)= A[M][K] x B[K][N].
// Operands are captured on an accepted start. One k-slice is applied per cycle across an
// MxN grid of multiply-accumulate cells. Accumulate mode lets several K-tiles be chained
// into one result.
module matmul_tile_mnk #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned M      = 2,
   parameter int unsigned N      = 2,
   parameter int unsigned K      = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     accumulate,
   input  logic signed [DATA_W-1:0] A [M][K],
   input  logic signed [DATA_W-1:0] B [K][N],
   output logic signed [ACC_W-1:0]  C [M][N],
   output logic                     busy,
   output logic                     done,
   output logic                     c_valid
);

   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned PW = 2 * DATA_W;
   localparam logic [KW-1:0] KLast = KW'(K - 1);

   // Reject builds where a full product would not fit in the accumulator.
   if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
      $error("ACC_W must be at least 2*DATA_W");
   end

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                   state_q, state_d;
   logic [KW-1:0]            k_q, k_d;
   logic signed [DATA_W-1:0] a_q [M][K];
   logic signed [DATA_W-1:0] a_d [M][K];
   logic signed [DATA_W-1:0] b_q [K][N];
   logic signed [DATA_W-1:0] b_d [K][N];
   logic signed [ACC_W-1:0]  c_q [M][N];
   logic signed [ACC_W-1:0]  c_d [M][N];
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     c_valid_q, c_valid_d;

   // Full-precision products for the current k-slice, sign-extended to accumulator width.
   logic signed [PW-1:0]     prod [M][N];
   logic signed [ACC_W-1:0]  prod_ext [M][N];

   // Products of the captured operands for the k-slice selected by the counter.
   always_comb begin
      for (int unsigned i = 0; i < M; i++) begin
         for (int unsigned j = 0; j < N; j++) begin
            prod[i][j]     = PW'(a_q[i][k_q]) * PW'(b_q[k_q][j]);
            prod_ext[i][j] = ACC_W'(prod[i][j]);
         end
      end
   end

   // Next-state: operand capture, accumulator update, k sequencing and status flags.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      done_d    = 1'b0;
      c_valid_d = c_valid_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               a_d       = A;
               b_d       = B;
               k_d       = '0;
               c_valid_d = 1'b0;
               state_d   = StRun;
               if (!accumulate) begin
                  for (int unsigned i = 0; i < M; i++) begin
                     for (int unsigned j = 0; j < N; j++) begin
                        c_d[i][j] = '0;
                     end
                  end
               end
            end
         end
         StRun: begin
            // Sums wrap modulo 2^ACC_W by construction.
            for (int unsigned i = 0; i < M; i++) begin
               for (int unsigned j = 0; j < N; j++) begin
                  c_d[i][j] = c_q[i][j] + prod_ext[i][j];
               end
            end
            if (k_q == KLast) begin
               state_d   = StIdle;
               done_d    = 1'b1;
               c_valid_d = 1'b1;
               k_d       = '0;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d == StRun);
   end

   // State and registered outputs; synchronous active-low reset aborts any run.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         k_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         c_valid_q <= 1'b0;
         for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned kk = 0; kk < K; kk++) begin
               a_q[i][kk] <= '0;
            end
         end
         for (int unsigned kk = 0; kk < K; kk++) begin
            for (int unsigned j = 0; j < N; j++) begin
               b_q[kk][j] <= '0;
            end
         end
         for (int unsigned i = 0; i < M; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
               c_q[i][j] <= '0;
            end
         end
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         c_valid_q <= c_valid_d;
         a_q       <= a_d;
         b_q       <= b_d;
         c_q       <= c_d;
      end
   end

   assign C       = c_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign c_valid = c_valid_q;

endmodule

// File: tb/tb_matmul_tile_mnk.sv
// Directed bench for matmul_tile_mnk: a 2x2x2 build and a 3x1x4 build on one clock.
module tb_matmul_tile_mnk;

   logic clk;
   logic rst_n;

   // 2x2x2 build
   logic              start;
   logic              accumulate;
   logic signed [7:0]  a [2][2];
   logic signed [7:0]  b [2][2];
   logic signed [31:0] c [2][2];
   logic              busy;
   logic              done;
   logic              c_valid;

   // 3x1x4 build
   logic              start2;
   logic              accumulate2;
   logic signed [7:0]  a2 [3][4];
   logic signed [7:0]  b2 [4][1];
   logic signed [31:0] c2 [3][1];
   logic              busy2;
   logic              done2;
   logic              c_valid2;

   int n_checks = 0;
   int n_fail   = 0;

   matmul_tile_mnk #(
      .DATA_W (8),
      .ACC_W  (32),
      .M      (2),
      .N      (2),
      .K      (2)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .accumulate (accumulate),
      .A          (a),
      .B          (b),
      .C          (c),
      .busy       (busy),
      .done       (done),
      .c_valid    (c_valid)
   );

   matmul_tile_mnk #(
      .DATA_W (8),
      .ACC_W  (32),
      .M      (3),
      .N      (1),
      .K      (4)
   ) u_dut_k4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start2),
      .accumulate (accumulate2),
      .A          (a2),
      .B          (b2),
      .C          (c2),
      .busy       (busy2),
      .done       (done2),
      .c_valid    (c_valid2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_c(input string tag, input int e00, input int e01,
                          input int e10, input int e11);
      check({tag, "_c00"}, c[0][0], e00);
      check({tag, "_c01"}, c[0][1], e01);
      check({tag, "_c10"}, c[1][0], e10);
      check({tag, "_c11"}, c[1][1], e11);
   endtask

   task automatic set_ab(input int a00, input int a01, input int a10, input int a11,
                         input int b00, input int b01, input int b10, input int b11);
      a[0][0] = 8'(a00); a[0][1] = 8'(a01); a[1][0] = 8'(a10); a[1][1] = 8'(a11);
      b[0][0] = 8'(b00); b[0][1] = 8'(b01); b[1][0] = 8'(b10); b[1][1] = 8'(b11);
   endtask

   task automatic randomize_ab();
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            a[i][j] = 8'($urandom);
            b[i][j] = 8'($urandom);
         end
      end
   endtask

   // One run on the 2x2x2 build, entered and left at a negedge; checks timing and flags.
   task automatic run1(input string tag, input logic accum);
      int lat;
      int bcnt;
      start      = 1'b1;
      accumulate = accum;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      bcnt  = 0;
      for (int t = 0; t < 20; t++) begin
         if (done) begin
            lat = t;
            break;
         end
         if (busy) bcnt++;
         if (t == 0) check({tag, "_cv_run"}, c_valid, 0);
         @(negedge clk);
      end
      check({tag, "_latency"}, lat, 2);
      check({tag, "_busy_cycles"}, bcnt, 2);
      check({tag, "_c_valid"}, c_valid, 1);
      check({tag, "_busy_at_done"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      logic [7:0] dmask;
      int ndone;
      int lat2;

      rst_n       = 1'b0;
      start       = 1'b0;
      accumulate  = 1'b0;
      start2      = 1'b0;
      accumulate2 = 1'b0;
      set_ab(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         for (int kk = 0; kk < 4; kk++) a2[i][kk] = '0;
      end
      for (int kk = 0; kk < 4; kk++) b2[kk][0] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_c("rst", 0, 0, 0, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_c_valid", c_valid, 0);
      check("rst_k4_c2", c2[2][0], 0);
      check("rst_k4_busy", busy2, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic product, clear mode
      set_ab(1, 2, 3, 4, 5, 6, 7, 8);
      run1("clr", 1'b0);
      check_c("clr", 19, 22, 43, 50);

      // Accumulate onto the previous result
      run1("acc", 1'b1);
      check_c("acc", 38, 44, 86, 100);

      // Signed extremes
      set_ab(-128, -128, -128, -128, -128, -128, -128, -128);
      run1("neg_neg", 1'b0);
      check_c("neg_neg", 32768, 32768, 32768, 32768);
      set_ab(-128, -128, -128, -128, 127, 127, 127, 127);
      run1("neg_pos", 1'b0);
      check_c("neg_pos", -32512, -32512, -32512, -32512);

      // 3x1x4 build
      a2[0][0] = 1;  a2[0][1] = 1; a2[0][2] = 1; a2[0][3] = 1;
      a2[1][0] = 1;  a2[1][1] = 2; a2[1][2] = 3; a2[1][3] = 4;
      a2[2][0] = -1; a2[2][1] = 0; a2[2][2] = 1; a2[2][3] = 0;
      b2[0][0] = 1;  b2[1][0] = 2; b2[2][0] = 3; b2[3][0] = 4;
      start2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start2 = 1'b0;
      lat2   = -1;
      for (int t = 0; t < 20; t++) begin
         if (done2) begin
            lat2 = t;
            break;
         end
         @(negedge clk);
      end
      check("k4_latency", lat2, 4);
      check("k4_c0", c2[0][0], 10);
      check("k4_c1", c2[1][0], 30);
      check("k4_c2", c2[2][0], 2);
      check("k4_c_valid", c_valid2, 1);

      // start held high, operands scrambled during RUN, back-to-back second run
      set_ab(1, 2, 3, 4, 5, 6, 7, 8);
      start      = 1'b1;
      accumulate = 1'b0;
      @(posedge clk);
      dmask = '0;
      ndone = 0;
      for (int t = 0; t < 8; t++) begin
         @(negedge clk);
         dmask[t] = done;
         if (done) ndone++;
         if (t == 2) begin
            if (done) check_c("hold1", 19, 22, 43, 50);
            set_ab(2, 0, 0, 2, 1, 2, 3, 4);
         end else begin
            if (t == 3) start = 1'b0;
            if (done && t == 5) check_c("hold2", 2, 4, 6, 8);
            randomize_ab();
         end
      end
      check("hold_done_mask", dmask, 8'b0010_0100);
      check("hold_done_count", ndone, 2);

      // Reset in the second RUN cycle aborts with no done pulse
      set_ab(1, 2, 3, 4, 5, 6, 7, 8);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_c("abort", 0, 0, 0, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_c_valid", c_valid, 0);
      rst_n = 1'b1;
      ndone = 0;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
